// File: rtl/pipe_adder_pkg.sv
// Shared ALU encodings: result-policy modes used by the pipelined adder.
package alu_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

endpackage

// File: rtl/pipe_adder_if.sv
// Valid/ready operand and result bus of the pipelined adder.
interface pipe_adder_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic             Cin;
  logic             sub;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             overflow;

  modport master (
    output in_valid, inp1, inp2, Cin, sub, mode, out_ready,
    input  in_ready, out_valid, sum, Cout, overflow
  );

  modport slave (
    input  in_valid, inp1, inp2, Cin, sub, mode, out_ready,
    output in_ready, out_valid, sum, Cout, overflow
  );
endinterface

// File: rtl/pipe_adder_chunk.sv
// One pipeline slice: W-bit ripple-carry adder exposing the carry into its MSB.
module adder_chunk
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         cMsb_o
);
  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int i = 0; i < W; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o    = carry[W];
  assign cMsb_o = carry[W-1];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: STAGE_W bits per stage, valid/ready flow control,
// wrap / zero-on-overflow / saturate result policies.
module pipe_adder
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STAGE_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_adder_if.slave  bus
);
  localparam int NSTAGE = WIDTH / STAGE_W;
  localparam int MSB    = WIDTH - 1;
  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Each slot carries the whole transaction so the untouched operand slices
  // and the sampled mode travel with their partial result.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             xovf;
    mode_e            mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] raw;
  } slot_t;

  slot_t              slot_q [NSTAGE];
  slot_t              slot_d [NSTAGE];
  slot_t              src    [NSTAGE];
  logic [STAGE_W-1:0] chA    [NSTAGE];
  logic [STAGE_W-1:0] chB    [NSTAGE];
  logic [STAGE_W-1:0] chS    [NSTAGE];
  logic               chCi   [NSTAGE];
  logic               chCo   [NSTAGE];
  logic               chMsb  [NSTAGE];
  logic               adv;
  slot_t              last;
  logic               ovf;

  assign last         = slot_q[NSTAGE-1];
  assign adv          = !last.valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    src[0]       = '0;
    src[0].valid = bus.in_valid;
    src[0].carry = bus.sub ? 1'b1 : bus.Cin;
    src[0].mode  = mode_e'(bus.mode);
    src[0].a     = bus.inp1;
    src[0].b     = bus.sub ? ~bus.inp2 : bus.inp2;
    for (int k = 1; k < NSTAGE; k++) src[k] = slot_q[k-1];
    for (int k = 0; k < NSTAGE; k++) begin
      chA[k]  = src[k].a[k*STAGE_W +: STAGE_W];
      chB[k]  = src[k].b[k*STAGE_W +: STAGE_W];
      chCi[k] = src[k].carry;
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    adder_chunk #(.W(STAGE_W)) u_chunk (
      .a_i    (chA[k]),
      .b_i    (chB[k]),
      .c_i    (chCi[k]),
      .s_o    (chS[k]),
      .c_o    (chCo[k]),
      .cMsb_o (chMsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      slot_d[k]                           = src[k];
      slot_d[k].raw[k*STAGE_W +: STAGE_W] = chS[k];
      slot_d[k].carry                     = chCo[k];
      slot_d[k].xovf                      = chMsb[k] ^ chCo[k];
    end
  end

  // The whole pipe moves in lockstep, so a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) slot_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSTAGE; k++) slot_q[k] <= slot_d[k];
    end
  end

  assign ovf = (last.a[MSB] == last.b[MSB]) && (last.raw[MSB] != last.a[MSB]);

  always_comb begin
    bus.sum = last.raw;
    case (last.mode)
      MODE_ZERO: if (ovf) bus.sum = '0;
      MODE_SAT:  if (ovf) bus.sum = last.a[MSB] ? SIGNED_MIN : SIGNED_MAX;
      default:   ;
    endcase
  end

  // Sign-based overflow must agree with the MSB carry-in/carry-out difference.
  always_comb begin
    if (last.valid) assert (ovf == last.xovf);
  end

  assign bus.out_valid = last.valid;
  assign bus.Cout      = last.carry;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=8, STAGE_W=4, latency 2).
module tb_pipe_adder;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] S_A   [6] = '{8'h01, 8'h10, 8'h20, 8'h7F, 8'hFF, 8'h33};
  localparam logic [7:0] S_B   [6] = '{8'h01, 8'h01, 8'h02, 8'h7F, 8'h01, 8'h44};
  localparam logic [7:0] S_EXP [6] = '{8'h02, 8'h11, 8'h22, 8'hFE, 8'h00, 8'h77};

  pipe_adder_if #(.WIDTH(8)) bus ();

  pipe_adder #(.WIDTH(8), .STAGE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic sb, input logic [1:0] md, input logic vld);
    bus.inp1     = a;
    bus.inp2     = b;
    bus.Cin      = cin;
    bus.sub      = sb;
    bus.mode     = md;
    bus.in_valid = vld;
  endtask

  // Entered and left 1 time unit after a rising edge with the pipe empty.
  task automatic runVector(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sb, input logic [1:0] md,
                           input logic [7:0] expSum, input logic expCout, input logic expOvf);
    checkOutput({tag, "_rdy"}, bus.in_ready, 1);
    applyStimulus(a, b, cin, sb, md, 1'b1);
    @(posedge clk); #1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput({tag, "_early"}, bus.out_valid, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_vld"},  bus.out_valid, 1);
    checkOutput({tag, "_sum"},  bus.sum, expSum);
    checkOutput({tag, "_cout"}, bus.Cout, expCout);
    checkOutput({tag, "_ovf"},  bus.overflow, expOvf);
    @(posedge clk); #1;
    checkOutput({tag, "_drain"}, bus.out_valid, 0);
  endtask

  initial begin
    int         sent;
    int         recv;
    logic [7:0] held;
    logic       stalled;

    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    bus.out_ready = 1'b1;
    #12;
    checkOutput("rst_vld",   bus.out_valid, 0);
    checkOutput("rst_rdy",   bus.in_ready, 1);
    checkOutput("rst_sum",   bus.sum, 0);
    checkOutput("rst_cout",  bus.Cout, 0);
    checkOutput("rst_ovf",   bus.overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rel_rdy", bus.in_ready, 1);

    runVector("wrap",     8'h7F, 8'h01, 1'b0, 1'b0, MODE_WRAP, 8'h80, 1'b0, 1'b1);
    runVector("zero_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, MODE_ZERO, 8'h00, 1'b0, 1'b1);
    runVector("zero_ok",  8'h10, 8'h20, 1'b0, 1'b0, MODE_ZERO, 8'h30, 1'b0, 1'b0);
    runVector("sat_neg",  8'h80, 8'hFF, 1'b0, 1'b0, MODE_SAT,  8'h80, 1'b1, 1'b1);
    runVector("sat_pos",  8'h70, 8'h70, 1'b0, 1'b0, MODE_SAT,  8'h7F, 1'b0, 1'b1);
    runVector("sat_ok",   8'hF0, 8'h05, 1'b0, 1'b0, MODE_SAT,  8'hF5, 1'b0, 1'b0);
    runVector("sub_neg",  8'h05, 8'h07, 1'b0, 1'b1, MODE_WRAP, 8'hFE, 1'b0, 1'b0);
    runVector("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, MODE_WRAP, 8'h7F, 1'b1, 1'b1);
    runVector("sub_cin",  8'h10, 8'h10, 1'b1, 1'b1, MODE_WRAP, 8'h00, 1'b1, 1'b0);
    runVector("cin_xfer", 8'h0F, 8'h00, 1'b1, 1'b0, MODE_WRAP, 8'h10, 1'b0, 1'b0);
    runVector("mode11",   8'h7F, 8'h01, 1'b0, 1'b0, MODE_RSVD, 8'h80, 1'b0, 1'b1);

    // Back-to-back stream with out_ready dropped for three cycles.
    sent    = 0;
    recv    = 0;
    held    = 8'h00;
    stalled = 1'b0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      if (sent < 6) applyStimulus(S_A[sent], S_B[sent], 1'b0, 1'b0, MODE_WRAP, 1'b1);
      else          applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
      bus.out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (bus.out_valid && !bus.out_ready) begin
        checkOutput("bp_inrdy", bus.in_ready, 0);
        if (stalled) checkOutput("bp_hold", bus.sum, held);
        held    = bus.sum;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput($sformatf("bp_res%0d", recv), bus.sum, S_EXP[recv]);
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    bus.out_ready = 1'b1;
    checkOutput("bp_count", recv, 6);
    checkOutput("bp_drain", bus.out_valid, 0);

    // Reset with two transactions in flight.
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, MODE_WRAP, 1'b1);
    @(posedge clk); #1;
    applyStimulus(8'h03, 8'h04, 1'b0, 1'b0, MODE_WRAP, 1'b1);
    @(posedge clk); #1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("mid_vld_pre", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_vld", bus.out_valid, 0);
    checkOutput("mid_sum", bus.sum, 0);
    checkOutput("mid_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("mid_rel_rdy", bus.in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("mid_quiet%0d", c), bus.out_valid, 0);
    end
    runVector("post_rst", 8'h22, 8'h11, 1'b1, 1'b0, MODE_WRAP, 8'h34, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have parameter STAGE_W, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of STAGE_W, and NSTAGE = WIDTH/STAGE_W.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input transaction this cycle.
- inp1  in  WIDTH  operand A, two's complement.
- inp2  in  WIDTH  operand B, two's complement.
- Cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 selects A+B+Cin; 1 selects A-B.
- mode  in  2  result policy: 00 wrap, 01 zero-on-overflow, 10 saturate, 11 treated as wrap.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  policy-adjusted result.
- Cout  out  1  carry out of the MSB.
- overflow  out  1  signed overflow flag.

Function
REQ-004 Handshake: a transfer occurs on a clock edge where valid=1 and ready=1, on both the input and output sides.
REQ-005 Global advance signal adv = !out_valid || out_ready; in_ready SHALL equal adv, and all pipeline registers SHALL update only when adv=1.
REQ-006 Latency SHALL be exactly NSTAGE cycles from input transfer to out_valid=1 when no stall occurs; throughput SHALL be one result per cycle.
REQ-007 Stage k SHALL add operand bits [k*STAGE_W +: STAGE_W] using the carry registered from stage k-1; stage 0 SHALL use carry-in Cin, or 1 when sub=1.
REQ-008 When sub=1, the effective B SHALL be ~inp2; Cout then means "no borrow".
REQ-009 Unused operand slices, together with mode and sub, SHALL be carried alongside each transaction; mode and sub SHALL be sampled only at the input transfer.
REQ-010 overflow SHALL be 1 exactly when A[MSB]==Beff[MSB] and raw[MSB]!=A[MSB].
REQ-011 Mode wrap: sum = raw.
REQ-012 Mode zero-on-overflow: sum = 0 when overflow=1, else raw.
REQ-013 Mode saturate: when overflow=1, sum = signed max (0111..1) if A[MSB]=0, else signed min (1000..0); otherwise sum = raw.
REQ-014 overflow and Cout SHALL always reflect the raw addition, independent of mode.
REQ-015 Bubbles (in_valid=0 while adv=1) SHALL advance through the pipeline as invalid slots; no reordering, loss or duplication is permitted.
REQ-016 While out_valid=1 and out_ready=0, sum, Cout and overflow SHALL hold stable.
REQ-017 Simultaneous output and input transfers in the same cycle SHALL both complete.

Reset
REQ-018 rst_n low SHALL asynchronously clear all stage valid bits, out_valid, sum, Cout and overflow to 0.
REQ-019 Transactions in flight at reset SHALL be discarded; none SHALL appear after rst_n deasserts.
REQ-020 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-021 Mode encodings (MODE_WRAP, MODE_ZERO, MODE_SAT) SHALL reside in shared package alu_pkg.
REQ-022 Each stage's combinational slice SHALL be sub-module adder_chunk: a STAGE_W-bit ripple-carry adder with carry-in, carry-out and MSB carry-in (used for the overflow cross-check).
REQ-023 The block SHALL contain no latches and no combinational path from in_valid to in_ready.

Verification (WIDTH=8, STAGE_W=4, latency 2)
REQ-024 wrap: 0x7F+0x01, Cin=0 -> sum 0x80, overflow 1, Cout 0, out_valid exactly 2 cycles after accept.
REQ-025 zero-on-overflow: 0x7F+0x01 -> sum 0x00, overflow 1; 0x10+0x20 -> sum 0x30, overflow 0.
REQ-026 saturate: 0x80+0xFF -> sum 0x80, overflow 1, Cout 1; 0x70+0x70 -> sum 0x7F, overflow 1.
REQ-027 sub: 0x05-0x07 -> sum 0xFE, Cout 0, overflow 0; 0x80-0x01 in wrap mode -> sum 0x7F, overflow 1.
REQ-028 backpressure: hold out_ready=0 for 3 cycles with a back-to-back stream -> in_ready 0, outputs stable, all results delivered in order with no loss.
REQ-029 reset mid-operation: assert rst_n low with 2 transactions in flight -> out_valid 0 immediately; no result appears after release until a new input is accepted.
